// File: rtl/fake_tpi_pkg.sv
// Shared constants for the clocked tri-port interface: register offsets, default
// geometry, interrupt edge encodings and the register-select decoder.
package fake_tpi_pkg;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_PORT_W    = 8;
    localparam int DEF_RS_W      = 3;
    localparam int DEF_INT_BITS  = 2;

    localparam int INT_EDGE_FALL = 0;
    localparam int INT_EDGE_RISE = 1;

    localparam int REG_PRA  = 0;
    localparam int REG_PRB  = 1;
    localparam int REG_PRC  = 2;
    localparam int REG_DDRA = 3;
    localparam int REG_DDRB = 4;
    localparam int REG_DDRC = 5;
    localparam int REG_IER  = 6;
    localparam int REG_IFR  = 7;

    typedef enum logic [2:0] {
        RK_NONE,
        RK_PR,
        RK_DDR,
        RK_IER,
        RK_IFR
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [1:0] idx;
    } reg_dec_t;

    function automatic reg_dec_t decode_rs(input int a);
        reg_dec_t d;
        d.kind = RK_NONE;
        d.idx  = 2'd0;
        case (a)
            REG_PRA:  begin d.kind = RK_PR;  d.idx = 2'd0; end
            REG_PRB:  begin d.kind = RK_PR;  d.idx = 2'd1; end
            REG_PRC:  begin d.kind = RK_PR;  d.idx = 2'd2; end
            REG_DDRA: begin d.kind = RK_DDR; d.idx = 2'd0; end
            REG_DDRB: begin d.kind = RK_DDR; d.idx = 2'd1; end
            REG_DDRC: begin d.kind = RK_DDR; d.idx = 2'd2; end
            REG_IER:  d.kind = RK_IER;
            REG_IFR:  d.kind = RK_IFR;
            default:  d.kind = RK_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tpi_sync2.sv
// Two-flop synchroniser for asynchronous inputs; RST_VAL sets the idle level it
// presents while and just after reset.
module tpi_sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking so the second stage takes the first stage's pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fake_tpi_sync.sv
// Clocked tri-port interface: register file, bus-cycle commit FSM, pin read-back
// and an edge-triggered interrupt on the low pins of the last port.
module fake_tpi_sync
    import fake_tpi_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PORT_W    = DEF_PORT_W,
    parameter int RS_W      = DEF_RS_W,
    parameter int INT_BITS  = DEF_INT_BITS,
    parameter int INT_EDGE  = INT_EDGE_FALL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [RS_W-1:0]             rs,
    input  logic                        _write,
    input  logic                        _cs,
    inout  wire  [7:0]                  data,
    inout  wire  [NUM_PORTS*PORT_W-1:0] port,
    output logic                        _irq
);
    localparam int         PW_ALL    = NUM_PORTS * PORT_W;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [7:0] INT_MASK  = 8'((9'd1 << INT_BITS) - 9'd1);
    localparam logic              EDGE_IDLE = (INT_EDGE == INT_EDGE_RISE);
    localparam logic [PW_ALL-1:0] PIN_IDLE  = {PW_ALL{EDGE_IDLE}};

    function automatic logic [7:0] pad8(input logic [PORT_W-1:0] v);
        logic [7:0] r;
        r = '0;
        r[PORT_W-1:0] = v;
        return r;
    endfunction

    logic              cs_s;
    logic [RS_W-1:0]   rs_s;
    logic [PW_ALL-1:0] pin_s;

    tpi_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(_cs), .q(cs_s)
    );
    tpi_sync2 #(.W(RS_W), .RST_VAL('0)) u_sync_rs (
        .clk(clk), .reset(reset), .d(rs), .q(rs_s)
    );
    tpi_sync2 #(.W(PW_ALL), .RST_VAL(PIN_IDLE)) u_sync_pin (
        .clk(clk), .reset(reset), .d(port), .q(pin_s)
    );

    logic [1:0]        state_q, state_d;
    logic              cs_prev_q, cs_prev_d;
    logic [1:0]        warm_q, warm_d;
    logic [RS_W-1:0]   hold_rs_q, hold_rs_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              hold_wr_n_q, hold_wr_n_d;
    logic [PW_ALL-1:0] pr_q, pr_d, ddr_q, ddr_d;
    logic [7:0]        ier_q, ier_d, ifr_q, ifr_d;
    logic [7:0]        pin_prev_q, pin_prev_d, rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic       cs_fall, cs_rise, commit;
    logic [7:0] pin_c8, edge_set, ifr_clr;
    reg_dec_t   wdec, rdec;

    // The strobe history is trusted only once the synchroniser has flushed its reset
    // level, so a cycle already under way at reset release never arms a commit.
    always_comb begin
        warm_d    = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        cs_prev_d = cs_s;
        cs_fall   = (warm_q == 2'd3) && cs_prev_q && !cs_s;
        cs_rise   = !cs_prev_q && cs_s;
        commit    = (state_q == ST_ARMED) && cs_rise && !hold_wr_n_q;
        state_d   = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_ARMED;
            ST_ARMED:  if (cs_rise) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every _d starts from its _q value so no path leaves it unassigned (no latch).
    always_comb begin
        hold_rs_d   = hold_rs_q;
        hold_data_d = hold_data_q;
        hold_wr_n_d = hold_wr_n_q;
        if (!_cs) begin
            hold_rs_d   = rs;
            hold_data_d = data;
            hold_wr_n_d = _write;
        end
    end

    always_comb begin
        wdec    = decode_rs(int'(hold_rs_q));
        pr_d    = pr_q;
        ddr_d   = ddr_q;
        ier_d   = ier_q;
        ifr_clr = '0;
        if (commit) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wdec.idx == 2'(p)) begin
                    if (wdec.kind == RK_PR)  pr_d[p*PORT_W +: PORT_W]  = hold_data_q[PORT_W-1:0];
                    if (wdec.kind == RK_DDR) ddr_d[p*PORT_W +: PORT_W] = hold_data_q[PORT_W-1:0];
                end
            end
            if (wdec.kind == RK_IER) ier_d   = hold_data_q & INT_MASK;
            if (wdec.kind == RK_IFR) ifr_clr = hold_data_q;
        end

        pin_c8     = pad8(pin_s[(NUM_PORTS-1)*PORT_W +: PORT_W]);
        pin_prev_d = pin_c8;
        if (INT_EDGE == INT_EDGE_RISE) edge_set = pin_c8 & ~pin_prev_q & INT_MASK;
        else                           edge_set = ~pin_c8 & pin_prev_q & INT_MASK;
        // A new edge wins over a write-1 clear landing in the same cycle.
        ifr_d = ((ifr_q & ~ifr_clr) | edge_set) & INT_MASK;
        irq_d = ~|(ifr_q & ier_q);
    end

    always_comb begin
        rdec    = decode_rs(int'(rs_s));
        rdata_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rdec.idx == 2'(p)) begin
                if (rdec.kind == RK_PR)
                    rdata_d = pad8((pr_q[p*PORT_W +: PORT_W] & ddr_q[p*PORT_W +: PORT_W]) |
                                   (pin_s[p*PORT_W +: PORT_W] & ~ddr_q[p*PORT_W +: PORT_W]));
                if (rdec.kind == RK_DDR)
                    rdata_d = pad8(ddr_q[p*PORT_W +: PORT_W]);
            end
        end
        if (rdec.kind == RK_IER) rdata_d = ier_q;
        if (rdec.kind == RK_IFR) rdata_d = ifr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cs_prev_q   <= 1'b1;
            warm_q      <= 2'd0;
            hold_rs_q   <= '0;
            hold_data_q <= '0;
            hold_wr_n_q <= 1'b0;
            pr_q        <= '0;
            ddr_q       <= '0;
            ier_q       <= '0;
            ifr_q       <= '0;
            pin_prev_q  <= {8{EDGE_IDLE}};
            rdata_q     <= '0;
            irq_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cs_prev_q   <= cs_prev_d;
            warm_q      <= warm_d;
            hold_rs_q   <= hold_rs_d;
            hold_data_q <= hold_data_d;
            hold_wr_n_q <= hold_wr_n_d;
            pr_q        <= pr_d;
            ddr_q       <= ddr_d;
            ier_q       <= ier_d;
            ifr_q       <= ifr_d;
            pin_prev_q  <= pin_prev_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    for (genvar i = 0; i < PW_ALL; i++) begin : g_pin
        assign port[i] = ddr_q[i] ? pr_q[i] : 1'bz;
    end

    assign data = (!_cs && _write) ? rdata_q : 8'bz;
    assign _irq = irq_q;

endmodule

// File: tb/tb_fake_tpi_sync.sv
// Self-checking bench for fake_tpi_sync: a default 8-bit build plus a 2-bit build,
// expected values queued when stimulus is applied and compared when the DUT answers.
module tb_fake_tpi_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rs;
    logic        write_n, cs_n, cs2_n;
    logic [7:0]  drv_data;
    logic        drv_en, drv_sel;
    logic [23:0] ext_en, ext_val;
    wire  [7:0]  data, data_n;
    wire  [23:0] port;
    wire  [5:0]  port_n;
    wire         irq_n, irq2_n;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign data   = (drv_en && !drv_sel) ? drv_data : 8'bz;
    assign data_n = (drv_en &&  drv_sel) ? drv_data : 8'bz;
    for (genvar i = 0; i < 24; i++) begin : g_ext
        assign port[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end
    assign port_n[5:4] = 2'b11;

    fake_tpi_sync dut (
        .clk(clk), .reset(reset), .rs(rs), ._write(write_n), ._cs(cs_n),
        .data(data), .port(port), ._irq(irq_n)
    );

    fake_tpi_sync #(.PORT_W(2)) dut_n (
        .clk(clk), .reset(reset), .rs(rs), ._write(write_n), ._cs(cs2_n),
        .data(data_n), .port(port_n), ._irq(irq2_n)
    );

    task automatic bus_write(input bit sel, input logic [2:0] a, input logic [7:0] v, input int idle);
        @(negedge clk);
        rs = a; write_n = 1'b0; drv_data = v; drv_sel = sel; drv_en = 1'b1;
        if (sel) cs2_n = 1'b0; else cs_n = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1; cs2_n = 1'b1; drv_en = 1'b0; write_n = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic bus_read(input bit sel, input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        rs = a; write_n = 1'b1;
        if (sel) cs2_n = 1'b0; else cs_n = 1'b0;
        repeat (4) @(negedge clk);
        v = sel ? data_n : data;
        cs_n = 1'b1; cs2_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] got, exp;
        exp_q.push_back(8'h01);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_irq: got %02h expected %02h", got, exp); end
        for (int i = 3; i < 8; i++) exp_q.push_back(8'h00);
        for (int i = 3; i < 8; i++) begin
            bus_read(1'b0, 3'(i), got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_rs%0d: got %02h expected %02h", i, got, exp); end
        end
    endtask

    task automatic test_port_out();
        logic [7:0] got, exp;
        bus_write(1'b0, 3'd3, 8'hFF, 5);
        bus_write(1'b0, 3'd0, 8'hA5, 0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hA5);
        repeat (2) @(negedge clk);
        got = port[7:0];
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL pra_pins_2clk: got %02h expected %02h", got, exp); end
        @(negedge clk);
        got = port[7:0];
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL pra_pins_3clk: got %02h expected %02h", got, exp); end
        repeat (3) @(negedge clk);
        exp_q.push_back(8'hA5);
        bus_read(1'b0, 3'd0, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL pra_read: got %02h expected %02h", got, exp); end
    endtask

    task automatic test_mixed_ddr();
        logic [7:0] got, exp;
        ext_en[15:12] = 4'hF; ext_val[15:12] = 4'h6;
        bus_write(1'b0, 3'd4, 8'h0F, 5);
        bus_write(1'b0, 3'd1, 8'hF3, 5);
        exp_q.push_back(8'h63);
        got = port[15:8];
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prb_pins: got %02h expected %02h", got, exp); end
        exp_q.push_back(8'h63);
        exp_q.push_back(8'h0F);
        bus_read(1'b0, 3'd1, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL prb_read: got %02h expected %02h", got, exp); end
        bus_read(1'b0, 3'd4, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ddrb_read: got %02h expected %02h", got, exp); end
    endtask

    task automatic test_irq();
        logic [7:0] got, exp;
        bus_write(1'b0, 3'd6, 8'h01, 5);
        @(negedge clk);
        ext_val[16] = 1'b0;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        repeat (3) @(negedge clk);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL irq_edge_3clk: got %02h expected %02h", got, exp); end
        @(negedge clk);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL irq_edge_4clk: got %02h expected %02h", got, exp); end
        exp_q.push_back(8'h01);
        bus_read(1'b0, 3'd7, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ifr_set: got %02h expected %02h", got, exp); end

        bus_write(1'b0, 3'd7, 8'h01, 0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        repeat (3) @(negedge clk);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL irq_clr_3clk: got %02h expected %02h", got, exp); end
        @(negedge clk);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL irq_clr_4clk: got %02h expected %02h", got, exp); end

        ext_val[16] = 1'b1;
        repeat (6) @(negedge clk);
        exp_q.push_back(8'h00);
        bus_read(1'b0, 3'd7, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ifr_rise_ignored: got %02h expected %02h", got, exp); end
    endtask

    task automatic test_clear_vs_set();
        logic [7:0] got, exp;
        @(negedge clk);
        ext_val[16] = 1'b0;
        repeat (6) @(negedge clk);
        exp_q.push_back(8'h00);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL irq_pre_collide: got %02h expected %02h", got, exp); end
        ext_val[16] = 1'b1;
        repeat (6) @(negedge clk);

        bus_write(1'b0, 3'd7, 8'h01, 0);
        ext_val[16] = 1'b0;
        for (int k = 1; k <= 6; k++) exp_q.push_back(8'h00);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            got = {7'd0, irq_n};
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL irq_collide_c%0d: got %02h expected %02h", k, got, exp); end
        end
        exp_q.push_back(8'h01);
        bus_read(1'b0, 3'd7, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ifr_collide: got %02h expected %02h", got, exp); end

        bus_write(1'b0, 3'd7, 8'h01, 5);
        exp_q.push_back(8'h01);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL irq_final_clear: got %02h expected %02h", got, exp); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] got, exp;
        @(negedge clk);
        rs = 3'd3; write_n = 1'b0; drv_data = 8'hFF; drv_sel = 1'b0; drv_en = 1'b1;
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1; drv_en = 1'b0; write_n = 1'b1;
        repeat (5) @(negedge clk);
        ext_en[15:8] = 8'h00;
        ext_en[7:0]  = 8'hFF; ext_val[7:0] = 8'h3C;
        repeat (2) @(negedge clk);

        exp_q.push_back(8'h01);
        exp_q.push_back(8'h3C);
        got = {7'd0, irq_n};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_irq: got %02h expected %02h", got, exp); end
        got = port[7:0];
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_pins_hiz: got %02h expected %02h", got, exp); end

        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h00);
        bus_read(1'b0, 3'd3, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_ddra: got %02h expected %02h", got, exp); end
        bus_read(1'b0, 3'd0, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_pra_pins: got %02h expected %02h", got, exp); end
        bus_read(1'b0, 3'd4, got);
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_ddrb: got %02h expected %02h", got, exp); end
    endtask

    task automatic test_narrow_port();
        logic [7:0] got, exp;
        logic [2:0] addrs [4];
        addrs = '{3'd1, 3'd4, 3'd6, 3'd7};
        bus_write(1'b1, 3'd4, 8'hFF, 5);
        bus_write(1'b1, 3'd1, 8'hFF, 5);
        bus_write(1'b1, 3'd6, 8'hFF, 5);
        exp_q.push_back(8'h03);
        got = {6'd0, port_n[3:2]};
        exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL narrow_pins: got %02h expected %02h", got, exp); end
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) begin
            bus_read(1'b1, addrs[i], got);
            exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL narrow_rs%0d: got %02h expected %02h", addrs[i], got, exp); end
        end
    endtask

    initial begin
        reset = 1'b1; rs = 3'd0; write_n = 1'b1; cs_n = 1'b1; cs2_n = 1'b1;
        drv_en = 1'b0; drv_sel = 1'b0; drv_data = 8'h00;
        ext_en = 24'h030000; ext_val = 24'h030000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        test_port_out();
        test_mixed_ddr();
        test_irq();
        test_clear_vs_set();
        test_reset_mid_write();
        test_narrow_port();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
